// File: rtl/lrot_8_seq.sv
// lrot_8_seq: sequential 8-bit left rotator with valid/ready handshake.
// Define LROT_8_SEQ_FAST_EN to load the full barrel result in one cycle.
module lrot_8_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic [2:0] sel,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready
);
  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] data_r;
  logic accept;
  assign accept    = (state == IDLE) && in_valid;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign out       = data_r;
`ifdef LROT_8_SEQ_FAST_EN
  logic [15:0] barrel;
  // upper byte of the doubled operand shifted left is the rotated value
  assign barrel = {data, data} << sel;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? DONE : IDLE;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      data_r <= '0;
    end else begin
      state <= state_nx;
      if (accept) data_r <= barrel[15:8];
    end
`else
  logic [2:0] cnt;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? (sel == 3'd0 ? DONE : ROT) : IDLE;
      ROT:     state_nx = cnt == 3'd1 ? DONE : ROT;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      data_r <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        data_r <= data;
        cnt    <= sel;
      end else if (state == ROT) begin
        data_r <= {data_r[6:0], data_r[7]};
        cnt    <= cnt - 3'd1;
      end
    end
`endif
endmodule
